// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, default width and divider state encoding
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;

    localparam int ALU_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    logic [WIDTH+1:0] diff;

    // One extra bit of headroom so the trial result's sign bit is unambiguous.
    always_comb begin
        diff  = {rem_i, bit_i} - {2'b00, divisor_i};
        q_o   = ~diff[WIDTH+1];
        rem_o = q_o ? diff[WIDTH:0] : {rem_i[WIDTH-1:0], bit_i};
    end

endmodule

// File: rtl/alu_div_seq.sv
// rtl/alu_div_seq.sv - sequential restoring divider for ALU opcode 110; ALU_DIV_SIGNED_EN enables two's complement operands
module alu_div_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic             zpend_q, zpend_d;

    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic [WIDTH-1:0] quot_u;
    logic [WIDTH-1:0] dvd_in, dvs_in, quot_fin, rem_fin, dvd_raw;
    logic             accept;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (prem_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    assign quot_u = {dvd_q[WIDTH-2:0], step_q};

`ifdef ALU_DIV_SIGNED_EN
    logic neg_q_q, neg_q_d, neg_r_q, neg_r_d;

    // Core always sees magnitudes; signs are reapplied on the completion edge.
    assign dvd_in   = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_in   = divisor[WIDTH-1] ? -divisor : divisor;
    assign quot_fin = neg_q_q ? -quot_u : quot_u;
    assign rem_fin  = neg_r_q ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
    assign dvd_raw  = neg_r_q ? -dvd_q : dvd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
        end
    end

    always_comb begin
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        if (accept) begin
            neg_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_d = dividend[WIDTH-1];
        end
    end
`else
    assign dvd_in   = dividend;
    assign dvs_in   = divisor;
    assign quot_fin = quot_u;
    assign rem_fin  = step_rem[WIDTH-1:0];
    assign dvd_raw  = dvd_q;
`endif

    assign accept = start && (state_q == IDLE || state_q == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            zpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            zpend_q <= zpend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        zpend_d = zpend_q;

        case (state_q)
            RUN: begin
                // Quotient bits shift into the vacated low end of the dividend register.
                prem_d = step_rem;
                dvd_d  = quot_u;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    dbz_d   = 1'b0;
                    quot_d  = quot_fin;
                    rem_d   = rem_fin;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (zpend_q) begin
                    quot_d  = '1;
                    rem_d   = dvd_raw;
                    dbz_d   = 1'b1;
                    done_d  = 1'b1;
                    zpend_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (accept) begin
            dvd_d  = dvd_in;
            dvs_d  = dvs_in;
            prem_d = '0;
            cnt_d  = CW'(WIDTH - 1);
            if (divisor != '0) begin
                state_d = RUN;
                busy_d  = 1'b1;
            end else begin
                state_d = DONE;
                zpend_d = 1'b1;
            end
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// tb/tb_alu_div_seq.sv - self-checking bench for alu_div_seq (ALU_DIV_SIGNED_EN selects signed expectations)
module tb_alu_div_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend, divisor, quotient, remainder;
    logic         busy, done, div_by_zero;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    alu_div_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        int sa, sb;
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
`ifdef ALU_DIV_SIGNED_EN
            sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
            sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
`else
            sa = int'(a);
            sb = int'(b);
`endif
            q = W'(sa / sb);
            r = W'(sa % sb);
            z = 1'b0;
        end
    endfunction

    task automatic pulse(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        chk("done_seen", done, 1'b1);
    endtask

    task automatic run_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        int lat, bcnt;
        pulse(a, b);
        wait_done(lat, bcnt);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dbz"}, div_by_zero, ez);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        chk({tag, "_lat"}, lat, ez ? 1 : W);
        chk({tag, "_busy_cycles"}, bcnt, ez ? 0 : W);
        @(negedge clk);
        chk({tag, "_done_width"}, done, 1'b0);
    endtask

    initial begin
        logic [W-1:0] q1, r1, q2, r2, a, b;
        logic         z1, z2;
        int           lat, bcnt, n;

`ifdef ALU_DIV_SIGNED_EN
        vecs.push_back('{4'b1001, 4'd2,    4'b1101, 4'b1111, 1'b0});
        vecs.push_back('{4'd7,    4'b1110, 4'b1101, 4'd1,    1'b0});
        vecs.push_back('{4'b1000, 4'b1111, 4'b1000, 4'd0,    1'b0});
        vecs.push_back('{4'b1011, 4'd3,    4'b1111, 4'b1110, 1'b0});
        vecs.push_back('{4'd5,    4'd3,    4'd1,    4'd2,    1'b0});
        vecs.push_back('{4'b1001, 4'd0,    4'hF,    4'b1001, 1'b1});
        vecs.push_back('{4'd7,    4'd0,    4'hF,    4'd7,    1'b1});
        vecs.push_back('{4'd0,    4'd5,    4'd0,    4'd0,    1'b0});
`else
        vecs.push_back('{4'd13, 4'd3,  4'd4,  4'd1,  1'b0});
        vecs.push_back('{4'd7,  4'd0,  4'hF,  4'd7,  1'b1});
        vecs.push_back('{4'd15, 4'd1,  4'd15, 4'd0,  1'b0});
        vecs.push_back('{4'd0,  4'd5,  4'd0,  4'd0,  1'b0});
        vecs.push_back('{4'd14, 4'd3,  4'd4,  4'd2,  1'b0});
        vecs.push_back('{4'd8,  4'd8,  4'd1,  4'd0,  1'b0});
        vecs.push_back('{4'd1,  4'd15, 4'd0,  4'd1,  1'b0});
        vecs.push_back('{4'd15, 4'd15, 4'd1,  4'd0,  1'b0});
`endif

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst = 1'b0;

        foreach (vecs[i])
            run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);

        // Second start while busy is ignored, then a start in the DONE cycle is taken.
        model(4'd9, 4'd5, q1, r1, z1);
        model(4'd6, 4'd2, q2, r2, z2);
        pulse(4'd9, 4'd5);
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 4'd6; divisor = 4'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("ign_lat", lat, 2);
        chk("ign_q", quotient, q1);
        chk("ign_r", remainder, r1);
        start = 1'b1; dividend = 4'd6; divisor = 4'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_hold_q", quotient, q1);
        chk("b2b_hold_r", remainder, r1);
        chk("b2b_busy", busy, 1'b1);
        wait_done(lat, bcnt);
        chk("b2b_lat", lat, W);
        chk("b2b_q", quotient, q2);
        chk("b2b_r", remainder, r2);

        // Asynchronous reset between edges mid-run.
        pulse(4'd12, 4'd4);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_dbz", div_by_zero, 0);
        #1 rst = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("abort_no_done", n, 0);
        model(4'd12, 4'd4, q1, r1, z1);
        run_check("after_abort", 4'd12, 4'd4, q1, r1, z1);

        // Results hold through the next operation's RUN phase.
        model(4'd14, 4'd3, q1, r1, z1);
        model(4'd8, 4'd8, q2, r2, z2);
        run_check("hold_first", 4'd14, 4'd3, q1, r1, z1);
        pulse(4'd8, 4'd8);
        repeat (2) begin
            chk("hold_q", quotient, q1);
            chk("hold_r", remainder, r1);
            @(negedge clk);
        end
        wait_done(lat, bcnt);
        chk("hold_new_q", quotient, q2);
        chk("hold_new_r", remainder, r2);

        for (int i = 0; i < 30; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            model(a, b, q1, r1, z1);
            run_check($sformatf("rnd%0d_%0h_%0h", i, a, b), a, b, q1, r1, z1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
